id_ex_controller: RTL and testbench
===================================

# id_ex_controller

Pipelined successor to the single-cycle decode controller. It decodes the instruction in the ID stage and registers the control bundle into the ID/EX pipeline register. It also detects load-use hazards, inserts bubbles on jump/branch flush, and runs a halt-drain state machine. It sits between the IF/ID register and the execute stage of the 5-stage core.

## Interface
- `INSTR_W`, 32: instruction width; opcode is `[INSTR_W-1:INSTR_W-6]`, funct is `[5:0]`.
- `ALU_OP_W`, 3: ALU operation code width; must be ≥3.
- `REG_W`, 5: register address width.
- `HALT_DRAIN`, 3: bubble cycles issued after `halt` before `halted` asserts; must be ≥1.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_b`, in, 1: asynchronous, active-low reset.
- `instruction`, in, `INSTR_W`: ID-stage instruction.
- `instr_valid`, in, 1: the ID instruction is real, not a bubble.
- `stall_b`, in, 1: active-low global freeze; when low, all registers hold.
- `branch_taken`, in, 1: EX resolved a taken beq/bne; kill the ID instruction.
- `ex_valid`, `ex_mem_read`, `ex_mem_write`, `ex_reg_write`, `ex_reg_dst`, `ex_mem_reg`, `ex_alu_src`, `ex_branch`, `ex_branch_ne`, `ex_jump`, out, 1 each: registered control.
- `ex_alu_op`, out, `ALU_OP_W`: registered ALU op.
- `ex_rs`, `ex_rt`, `ex_rd`, out, `REG_W` each: registered register fields.
- `pc_hold`, out, 1: combinational; PC and IF/ID must hold this cycle.
- `if_flush`, out, 1: combinational; IF/ID loads a bubble next edge.
- `halted`, out, 1: registered; the core is stopped.
- `illegal`, out, 1: registered, sticky; an undefined opcode or funct was seen.

## Operation
- ALU op codes: 0 add, 1 nop/pass, 2 and, 3 or, 4 slt, 6 sub.
- Decode table (ALU op, then asserted controls):
  - R-type, opcode 0x00, funct 0x20/0x22/0x24/0x25/0x2a: ALU op add/sub/and/or/slt; reg_dst, reg_write.
  - lw, 0x23: ALU op add; mem_read, mem_reg, alu_src, reg_write.
  - sw, 0x2b: ALU op add; mem_write, alu_src.
  - addi, 0x08: ALU op add; alu_src, reg_write.
  - beq, 0x04: ALU op sub; branch.
  - bne, 0x05: ALU op sub; branch, branch_ne.
  - j, 0x02: jump. `if_flush` = 1 in the decode cycle.
  - halt, 0x3f: see the halt FSM.
- A bubble is the all-zero bundle with `ex_alu_op` = 1 and `ex_valid` = 0.
- Undefined opcode or R-type funct: issue a bubble and set `illegal`.
- Load-use hazard, evaluated combinationally:
  - Condition: `ex_valid & ex_mem_read & ex_rt≠0`, and `ex_rt` equals rs, or equals rt when the instruction reads rt (R-type, sw, beq, bne).
  - Response: `pc_hold` = 1, bubble into ID/EX, ID instruction retained.
- Priority, highest first: `stall_b` low (hold everything) > `branch_taken` (bubble, `if_flush` = 1, suppress halt/jump/hazard) > halted > halt decode > load-use > normal decode.
- Halt FSM, states RUN, DRAIN, HALTED:
  - RUN → DRAIN on a valid, unflushed halt: bubble issued, drain counter loaded with `HALT_DRAIN`-1.
  - DRAIN: `pc_hold` = 1, bubbles issued, counter decrements; at 0 → HALTED.
  - HALTED: `halted` = 1, `pc_hold` = 1, bubbles issued; exits only on reset.
- `stall_b` low freezes the FSM and the counter.

## Timing
- Reset values (async, on `rst_b` low): all `ex_*` = 0 except `ex_alu_op` = 1; `halted` = 0; `illegal` = 0; FSM = RUN; counter = 0.
- Decode to `ex_*` latency: 1 clock.
- `pc_hold` and `if_flush` are same-cycle combinational.
- Load-use costs exactly one bubble. The retried instruction issues on the next edge.
- `halted` rises `HALT_DRAIN` edges after the halt is accepted.
- Reset mid-DRAIN returns to RUN with no residual count.
- `instr_valid` = 0 always issues a bubble, even if it matches a hazard.

## Structure
- Shared package `cpu_pkg`: opcode and funct constants, ALU op localparams, control bundle struct, halt state enum.
- One sub-module, `instr_decode`: purely combinational opcode/funct to bundle plus an `illegal` flag.
- This block holds the pipeline register, hazard logic and halt FSM.

## Test plan
- Reset: hold `rst_b` low mid-stream → all `ex_*` are 0 with `ex_alu_op` = 1, `halted` = 0. Release, then `add $3,$1,$2` (0x00221820) → next edge `ex_reg_write` = 1, `ex_reg_dst` = 1, `ex_alu_op` = 0, `ex_rd` = 3.
- Load-use: `lw $2,0($1)` then `add $3,$2,$4` → one cycle of `pc_hold` = 1 with an `ex_valid` = 0 bubble, then the add issues. Repeat with `lw $0` → no stall.
- Flush: `branch_taken` = 1 while ID holds halt → bubble, `if_flush` = 1, FSM stays RUN. Separately, `j` → `if_flush` = 1, `ex_jump` = 1.
- Halt with `HALT_DRAIN` = 3 → `halted` after 3 edges. Apply `stall_b` low for 2 cycles mid-drain → `halted` delays by 2. Reset during DRAIN → RUN.
- Illegal: opcode 0x3e, then funct 0x07 → bubbles; `illegal` stays 1 until reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared decode constants, ALU op codes, control bundle and halt FSM states
// for the ID/EX controller.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3f;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_NOP = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_SUB = 3'd6;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_reg;
    logic       alu_src;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic [2:0] alu_op;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } halt_state_t;

  // A bubble carries no side effects and a pass-through ALU op.
  function automatic ctrl_t bubble_ctrl();
    ctrl_t c;
    c = '0;
    c.alu_op = ALU_NOP;
    return c;
  endfunction

endpackage

// File: rtl/id_ex_controller_if.sv
// ID-stage request and ID/EX control bundle between the IF/ID side
// (master) and the ID/EX controller (slave).
interface id_ex_controller_if #(
  parameter int INSTR_W  = 32,
  parameter int ALU_OP_W = 3,
  parameter int REG_W    = 5
);

  logic [INSTR_W-1:0]  instruction;
  logic                instr_valid;
  logic                stall_b;
  logic                branch_taken;

  logic                ex_valid;
  logic                ex_mem_read;
  logic                ex_mem_write;
  logic                ex_reg_write;
  logic                ex_reg_dst;
  logic                ex_mem_reg;
  logic                ex_alu_src;
  logic                ex_branch;
  logic                ex_branch_ne;
  logic                ex_jump;
  logic [ALU_OP_W-1:0] ex_alu_op;
  logic [REG_W-1:0]    ex_rs;
  logic [REG_W-1:0]    ex_rt;
  logic [REG_W-1:0]    ex_rd;

  logic                pc_hold;
  logic                if_flush;
  logic                halted;
  logic                illegal;

  modport master (
    output instruction, instr_valid, stall_b, branch_taken,
    input  ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_reg_dst,
           ex_mem_reg, ex_alu_src, ex_branch, ex_branch_ne, ex_jump,
           ex_alu_op, ex_rs, ex_rt, ex_rd, pc_hold, if_flush, halted, illegal
  );

  modport slave (
    input  instruction, instr_valid, stall_b, branch_taken,
    output ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_reg_dst,
           ex_mem_reg, ex_alu_src, ex_branch, ex_branch_ne, ex_jump,
           ex_alu_op, ex_rs, ex_rt, ex_rd, pc_hold, if_flush, halted, illegal
  );

endinterface

// File: rtl/instr_decode.sv
// Combinational opcode/funct decode into the control bundle, with flags for
// halt, undefined encodings and whether the instruction reads rt.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       is_halt,
  output logic       illegal,
  output logic       reads_rt
);

  always_comb begin
    ctrl     = bubble_ctrl();
    is_halt  = 1'b0;
    illegal  = 1'b0;
    reads_rt = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        reads_rt       = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_op = ALU_ADD;
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          default: begin
            ctrl    = bubble_ctrl();
            illegal = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.mem_read  = 1'b1;
        ctrl.mem_reg   = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_SW: begin
        reads_rt       = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_ADDI: begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_BEQ: begin
        reads_rt    = 1'b1;
        ctrl.alu_op = ALU_SUB;
        ctrl.branch = 1'b1;
      end
      OP_BNE: begin
        reads_rt       = 1'b1;
        ctrl.alu_op    = ALU_SUB;
        ctrl.branch    = 1'b1;
        ctrl.branch_ne = 1'b1;
      end
      OP_J:    ctrl.jump = 1'b1;
      OP_HALT: is_halt   = 1'b1;
      default: illegal   = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_controller.sv
// ID/EX pipeline register with load-use hazard detection, branch/jump flush
// and a halt-drain state machine.
module id_ex_controller
  import cpu_pkg::*;
#(
  parameter int INSTR_W    = 32,
  parameter int ALU_OP_W   = 3,
  parameter int REG_W      = 5,
  parameter int HALT_DRAIN = 3
) (
  input logic               clk,
  input logic               rst_b,
  id_ex_controller_if.slave bus
);

  localparam int OP_LSB = INSTR_W - 6;
  localparam int CNT_W  = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;

  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic [REG_W-1:0] rd;
  logic             unused_instr_bits;

  assign opcode            = bus.instruction[INSTR_W-1 -: 6];
  assign funct             = bus.instruction[5:0];
  assign rs                = bus.instruction[OP_LSB-1 -: REG_W];
  assign rt                = bus.instruction[OP_LSB-1-REG_W -: REG_W];
  assign rd                = bus.instruction[OP_LSB-1-2*REG_W -: REG_W];
  assign unused_instr_bits = ^bus.instruction;

  ctrl_t dec_ctrl;
  logic  dec_halt;
  logic  dec_illegal;
  logic  dec_reads_rt;

  instr_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .ctrl    (dec_ctrl),
    .is_halt (dec_halt),
    .illegal (dec_illegal),
    .reads_rt(dec_reads_rt)
  );

  ctrl_t            ex_ctrl;
  logic             ex_valid_q;
  logic [REG_W-1:0] ex_rs_q;
  logic [REG_W-1:0] ex_rt_q;
  logic [REG_W-1:0] ex_rd_q;
  halt_state_t      state;
  logic [CNT_W-1:0] drain_cnt;
  logic             halted_q;
  logic             illegal_q;

  logic load_use;
  logic issue;
  logic accept_halt;
  logic set_illegal;
  logic hold_id;

  assign load_use = bus.instr_valid & ex_valid_q & ex_ctrl.mem_read &
                    (ex_rt_q != '0) &
                    ((ex_rt_q == rs) | (dec_reads_rt & (ex_rt_q == rt)));

  // Priority chain for the ID instruction; anything not issued becomes a bubble.
  always_comb begin
    issue       = 1'b0;
    accept_halt = 1'b0;
    set_illegal = 1'b0;
    hold_id     = 1'b0;
    if (!bus.branch_taken) begin
      if (state != ST_RUN) begin
        hold_id = 1'b1;
      end else if (bus.instr_valid) begin
        if (dec_halt)         accept_halt = 1'b1;
        else if (load_use)    hold_id     = 1'b1;
        else if (dec_illegal) set_illegal = 1'b1;
        else                  issue       = 1'b1;
      end
    end
  end

  assign bus.pc_hold  = bus.stall_b & hold_id;
  assign bus.if_flush = bus.stall_b & (bus.branch_taken | (issue & dec_ctrl.jump));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ex_ctrl    <= bubble_ctrl();
      ex_valid_q <= 1'b0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_rd_q    <= '0;
      state      <= ST_RUN;
      drain_cnt  <= '0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (bus.stall_b) begin
      if (issue) begin
        ex_ctrl    <= dec_ctrl;
        ex_valid_q <= 1'b1;
        ex_rs_q    <= rs;
        ex_rt_q    <= rt;
        ex_rd_q    <= rd;
      end else begin
        ex_ctrl    <= bubble_ctrl();
        ex_valid_q <= 1'b0;
        ex_rs_q    <= '0;
        ex_rt_q    <= '0;
        ex_rd_q    <= '0;
      end
      if (set_illegal) illegal_q <= 1'b1;
      case (state)
        ST_RUN: begin
          if (accept_halt) begin
            state     <= ST_DRAIN;
            drain_cnt <= CNT_W'(HALT_DRAIN - 1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            state    <= ST_HALTED;
            halted_q <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - CNT_W'(1);
          end
        end
        ST_HALTED: halted_q <= 1'b1;
        default:   state    <= ST_RUN;
      endcase
    end
  end

  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_mem_read  = ex_ctrl.mem_read;
  assign bus.ex_mem_write = ex_ctrl.mem_write;
  assign bus.ex_reg_write = ex_ctrl.reg_write;
  assign bus.ex_reg_dst   = ex_ctrl.reg_dst;
  assign bus.ex_mem_reg   = ex_ctrl.mem_reg;
  assign bus.ex_alu_src   = ex_ctrl.alu_src;
  assign bus.ex_branch    = ex_ctrl.branch;
  assign bus.ex_branch_ne = ex_ctrl.branch_ne;
  assign bus.ex_jump      = ex_ctrl.jump;
  assign bus.ex_alu_op    = ALU_OP_W'(ex_ctrl.alu_op);
  assign bus.ex_rs        = ex_rs_q;
  assign bus.ex_rt        = ex_rt_q;
  assign bus.ex_rd        = ex_rd_q;
  assign bus.halted       = halted_q;
  assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_id_ex_controller.sv
// Bench for id_ex_controller: directed scenarios plus a randomized stream
// checked against a table-driven pipeline model.
module tb_id_ex_controller;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  id_ex_controller_if #(.INSTR_W(32), .ALU_OP_W(3), .REG_W(5)) bus ();

  id_ex_controller #(
    .INSTR_W(32), .ALU_OP_W(3), .REG_W(5), .HALT_DRAIN(3)
  ) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       valid;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_reg;
    logic       alu_src;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic [2:0] alu_op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } exp_t;

  localparam logic [31:0] I_ADD_3_1_2 = 32'h0022_1820;
  localparam logic [31:0] I_LW_2_1    = 32'h8C22_0000;
  localparam logic [31:0] I_ADD_3_2_4 = 32'h0044_1820;
  localparam logic [31:0] I_LW_0_1    = 32'h8C20_0000;
  localparam logic [31:0] I_ADD_3_0_4 = 32'h0004_1820;
  localparam logic [31:0] I_HALT      = 32'hFC00_0000;
  localparam logic [31:0] I_J         = 32'h0800_0010;
  localparam logic [31:0] I_BAD_OP    = 32'hF800_0000;
  localparam logic [31:0] I_BAD_FN    = 32'h0000_0007;

  function automatic exp_t bubble();
    exp_t b;
    b = '0;
    b.alu_op = 3'd1;
    return b;
  endfunction

  // Expected bundle straight from the decode table.
  function automatic exp_t ref_decode(input logic [31:0] i);
    exp_t e;
    e = bubble();
    e.valid = 1'b1;
    e.rs = i[25:21];
    e.rt = i[20:16];
    e.rd = i[15:11];
    case (i[31:26])
      6'h00: begin
        e.reg_dst = 1'b1;
        e.reg_write = 1'b1;
        case (i[5:0])
          6'h20: e.alu_op = 3'd0;
          6'h22: e.alu_op = 3'd6;
          6'h24: e.alu_op = 3'd2;
          6'h25: e.alu_op = 3'd3;
          6'h2a: e.alu_op = 3'd4;
          default: e = bubble();
        endcase
      end
      6'h23: begin
        e.alu_op = 3'd0; e.mem_read = 1'b1; e.mem_reg = 1'b1;
        e.alu_src = 1'b1; e.reg_write = 1'b1;
      end
      6'h2b: begin e.alu_op = 3'd0; e.mem_write = 1'b1; e.alu_src = 1'b1; end
      6'h08: begin e.alu_op = 3'd0; e.alu_src = 1'b1; e.reg_write = 1'b1; end
      6'h04: begin e.alu_op = 3'd6; e.branch = 1'b1; end
      6'h05: begin e.alu_op = 3'd6; e.branch = 1'b1; e.branch_ne = 1'b1; end
      6'h02: e.jump = 1'b1;
      default: e = bubble();
    endcase
    return e;
  endfunction

  function automatic logic reads_rt(input logic [31:0] i);
    return (i[31:26] == 6'h00) || (i[31:26] == 6'h2b) ||
           (i[31:26] == 6'h04) || (i[31:26] == 6'h05);
  endfunction

  function automatic exp_t observed();
    return {bus.ex_valid, bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write,
            bus.ex_reg_dst, bus.ex_mem_reg, bus.ex_alu_src, bus.ex_branch,
            bus.ex_branch_ne, bus.ex_jump, bus.ex_alu_op, bus.ex_rs, bus.ex_rt,
            bus.ex_rd};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  s, t, d;
    logic [5:0]  fn [5];
    logic [5:0]  ops [6];
    int          k;
    fn  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    ops = '{6'h23, 6'h2b, 6'h08, 6'h04, 6'h05, 6'h02};
    s = 5'($urandom_range(0, 3));
    t = 5'($urandom_range(0, 3));
    d = 5'($urandom_range(0, 31));
    k = $urandom_range(0, 10);
    if (k < 5) return {6'h00, s, t, d, 5'd0, fn[k]};
    if (ops[k-5] == 6'h02) return {6'h02, 26'($urandom)};
    return {ops[k-5], s, t, 16'($urandom)};
  endfunction

  task automatic applyStimulus(input logic [31:0] instr, input logic valid,
                               input logic stall_b, input logic branch);
    bus.instruction  = instr;
    bus.instr_valid  = valid;
    bus.stall_b      = stall_b;
    bus.branch_taken = branch;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    rst_b = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    applyStimulus(I_LW_2_1, 1'b1, 1'b1, 1'b0);
    tick();
    rst_b = 1'b0;
    #1;
    checks++;
    if (observed() !== bubble()) begin
      errors++;
      $display("[TB] FAIL reset_bundle: got %h want %h", observed(), bubble());
    end
    checks++;
    if (bus.halted !== 1'b0 || bus.illegal !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: halted %b illegal %b want 0 0", bus.halted, bus.illegal);
    end
    tick();
    rst_b = 1'b1;
    applyStimulus(I_ADD_3_1_2, 1'b1, 1'b1, 1'b0);
    tick();
    checks++;
    if (bus.ex_reg_write !== 1'b1 || bus.ex_reg_dst !== 1'b1 ||
        bus.ex_alu_op !== 3'd0 || bus.ex_rd !== 5'd3) begin
      errors++;
      $display("[TB] FAIL reset_first_add: rw %b dst %b op %0d rd %0d want 1 1 0 3",
               bus.ex_reg_write, bus.ex_reg_dst, bus.ex_alu_op, bus.ex_rd);
    end
    e = ref_decode(I_ADD_3_1_2);
    checks++;
    if (observed() !== e) begin
      errors++;
      $display("[TB] FAIL reset_first_bundle: got %h want %h", observed(), e);
    end
  endtask

  task automatic test_load_use();
    applyStimulus(I_LW_2_1, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(I_ADD_3_2_4, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.pc_hold !== 1'b1 || bus.if_flush !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_use_hold: pc_hold %b if_flush %b want 1 0", bus.pc_hold, bus.if_flush);
    end
    tick();
    checks++;
    if (observed() !== bubble()) begin
      errors++;
      $display("[TB] FAIL load_use_bubble: got %h want %h", observed(), bubble());
    end
    checks++;
    if (bus.pc_hold !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_use_release: pc_hold %b want 0", bus.pc_hold);
    end
    tick();
    checks++;
    if (observed() !== ref_decode(I_ADD_3_2_4)) begin
      errors++;
      $display("[TB] FAIL load_use_retry: got %h want %h", observed(), ref_decode(I_ADD_3_2_4));
    end
    applyStimulus(I_LW_0_1, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(I_ADD_3_0_4, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.pc_hold !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_use_r0: pc_hold %b want 0", bus.pc_hold);
    end
    tick();
    checks++;
    if (observed() !== ref_decode(I_ADD_3_0_4)) begin
      errors++;
      $display("[TB] FAIL load_use_r0_issue: got %h want %h", observed(), ref_decode(I_ADD_3_0_4));
    end
    applyStimulus(I_LW_2_1, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(I_ADD_3_2_4, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.pc_hold !== 1'b0) begin
      errors++;
      $display("[TB] FAIL invalid_hazard_hold: pc_hold %b want 0", bus.pc_hold);
    end
    tick();
    checks++;
    if (observed() !== bubble()) begin
      errors++;
      $display("[TB] FAIL invalid_bubble: got %h want %h", observed(), bubble());
    end
  endtask

  task automatic test_flush();
    applyStimulus(I_HALT, 1'b1, 1'b1, 1'b1);
    checks++;
    if (bus.if_flush !== 1'b1 || bus.pc_hold !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_halt_comb: if_flush %b pc_hold %b want 1 0", bus.if_flush, bus.pc_hold);
    end
    tick();
    checks++;
    if (observed() !== bubble() || bus.halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_halt_bubble: got %h halted %b want %h 0", observed(), bus.halted, bubble());
    end
    applyStimulus(I_ADD_3_1_2, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.pc_hold !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_still_run: pc_hold %b want 0", bus.pc_hold);
    end
    tick();
    checks++;
    if (observed() !== ref_decode(I_ADD_3_1_2)) begin
      errors++;
      $display("[TB] FAIL flush_next_issue: got %h want %h", observed(), ref_decode(I_ADD_3_1_2));
    end
    applyStimulus(I_J, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.if_flush !== 1'b1) begin
      errors++;
      $display("[TB] FAIL jump_flush: if_flush %b want 1", bus.if_flush);
    end
    tick();
    checks++;
    if (observed() !== ref_decode(I_J) || bus.ex_jump !== 1'b1) begin
      errors++;
      $display("[TB] FAIL jump_issue: got %h want %h", observed(), ref_decode(I_J));
    end
  endtask

  task automatic test_halt();
    int n;
    do_reset();
    applyStimulus(I_HALT, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(I_ADD_3_1_2, 1'b1, 1'b1, 1'b0);
    n = 0;
    while (bus.halted !== 1'b1 && n < 20) begin
      checks++;
      if (bus.pc_hold !== 1'b1 || observed() !== bubble()) begin
        errors++;
        $display("[TB] FAIL drain_cycle: pc_hold %b bundle %h want 1 %h", bus.pc_hold, observed(), bubble());
      end
      tick();
      n++;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("[TB] FAIL halt_latency: got %0d edges want 3", n);
    end
    tick();
    checks++;
    if (bus.halted !== 1'b1 || bus.pc_hold !== 1'b1 || observed() !== bubble()) begin
      errors++;
      $display("[TB] FAIL halted_state: halted %b pc_hold %b bundle %h want 1 1 %h",
               bus.halted, bus.pc_hold, observed(), bubble());
    end

    do_reset();
    applyStimulus(I_HALT, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    n = 1;
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    n += 2;
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
    while (bus.halted !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("[TB] FAIL halt_stall_latency: got %0d edges want 5", n);
    end

    do_reset();
    applyStimulus(I_HALT, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    rst_b = 1'b0;
    #1;
    rst_b = 1'b1;
    applyStimulus(I_ADD_3_1_2, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.pc_hold !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_reset_run: pc_hold %b want 0", bus.pc_hold);
    end
    tick();
    checks++;
    if (observed() !== ref_decode(I_ADD_3_1_2)) begin
      errors++;
      $display("[TB] FAIL drain_reset_issue: got %h want %h", observed(), ref_decode(I_ADD_3_1_2));
    end
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (bus.halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_reset_residual: halted %b want 0", bus.halted);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    applyStimulus(I_BAD_OP, 1'b1, 1'b1, 1'b0);
    tick();
    checks++;
    if (observed() !== bubble() || bus.illegal !== 1'b1) begin
      errors++;
      $display("[TB] FAIL illegal_opcode: bundle %h illegal %b want %h 1", observed(), bus.illegal, bubble());
    end
    applyStimulus(I_BAD_FN, 1'b1, 1'b1, 1'b0);
    tick();
    checks++;
    if (observed() !== bubble() || bus.illegal !== 1'b1) begin
      errors++;
      $display("[TB] FAIL illegal_funct: bundle %h illegal %b want %h 1", observed(), bus.illegal, bubble());
    end
    applyStimulus(I_ADD_3_1_2, 1'b1, 1'b1, 1'b0);
    tick();
    checks++;
    if (observed() !== ref_decode(I_ADD_3_1_2) || bus.illegal !== 1'b1) begin
      errors++;
      $display("[TB] FAIL illegal_sticky: bundle %h illegal %b want %h 1",
               observed(), bus.illegal, ref_decode(I_ADD_3_1_2));
    end
    do_reset();
    checks++;
    if (bus.illegal !== 1'b0) begin
      errors++;
      $display("[TB] FAIL illegal_clear: illegal %b want 0", bus.illegal);
    end
  endtask

  // Random stream; the bench plays IF/ID, retaining on hold and bubbling on flush.
  task automatic test_random();
    exp_t        exp_q, nxt;
    logic [31:0] cur;
    logic        cur_valid, stall, br, m_hold, m_flush;
    do_reset();
    exp_q = bubble();
    cur = rand_instr();
    cur_valid = 1'b1;
    for (int it = 0; it < 400; it++) begin
      stall = ($urandom_range(0, 9) != 0);
      br    = ($urandom_range(0, 9) == 0);
      applyStimulus(cur, cur_valid, stall, br);
      m_hold = 1'b0;
      m_flush = 1'b0;
      nxt = exp_q;
      if (stall) begin
        if (br) begin
          nxt = bubble();
          m_flush = 1'b1;
        end else if (!cur_valid) begin
          nxt = bubble();
        end else if (exp_q.valid && exp_q.mem_read && exp_q.rt != 5'd0 &&
                     (exp_q.rt == cur[25:21] || (reads_rt(cur) && exp_q.rt == cur[20:16]))) begin
          nxt = bubble();
          m_hold = 1'b1;
        end else begin
          nxt = ref_decode(cur);
          m_flush = nxt.jump;
        end
      end
      checks++;
      if (bus.pc_hold !== m_hold || bus.if_flush !== m_flush) begin
        errors++;
        $display("[TB] FAIL rand_comb[%0d]: pc_hold %b if_flush %b want %b %b",
                 it, bus.pc_hold, bus.if_flush, m_hold, m_flush);
      end
      tick();
      exp_q = nxt;
      checks++;
      if (observed() !== exp_q) begin
        errors++;
        $display("[TB] FAIL rand_bundle[%0d]: got %h want %h", it, observed(), exp_q);
      end
      if (stall && !m_hold) begin
        if (m_flush) begin
          cur = rand_instr();
          cur_valid = 1'b0;
        end else begin
          cur = rand_instr();
          cur_valid = ($urandom_range(0, 4) != 0);
        end
      end
    end
    checks++;
    if (bus.halted !== 1'b0 || bus.illegal !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rand_flags: halted %b illegal %b want 0 0", bus.halted, bus.illegal);
    end
  endtask

  initial begin
    rst_b = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
    test_reset();
    test_load_use();
    test_flush();
    test_halt();
    test_illegal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
